// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC controller for the IF stage of the 5-stage MIPS pipeline. It drives
// the D/CE inputs of the external 32-bit PC register and reads its Q back.
// It selects between sequential, branch/jump, exception-vector and ERET
// targets, parks a branch redirect that arrives while fetch cannot advance,
// and holds the PC for a short boot window after reset.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc_q              current PC from the PC register
//   pc_d, pc_ce       next PC and write enable for the PC register
//   stall             IF/ID stall from the hazard unit
//   imem_ready        instruction memory has acknowledged the current fetch
//   br_valid/target   taken branch/jump from ID (1-cycle pulse)
//   exc_req           exception taken in MEM (1-cycle pulse)
//   eret, epc         ERET committed and the EPC to return to
//   if_flush          kill the instruction held in IF/ID
//   fetch_valid       IF instruction is valid this cycle
//   fetch_adel        registered misaligned-fetch flag
//   busy_boot         sequencer is still in its boot hold
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC   = 32'hBFC00000,
    parameter logic [31:0] EXC_VEC     = 32'hBFC00380,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_d,
    output logic        pc_ce,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        if_flush,
    output logic        fetch_valid,
    output logic        fetch_adel,
    output logic        busy_boot
);

    localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] boot_cnt, next_cnt;
    logic [31:0]   pend_target, next_pend;
    logic          advance;

    // Fetch may only move on when the hazard unit is not stalling and the
    // instruction memory has delivered the current word.
    assign advance = !stall && imem_ready;

    // State, boot counter, parked redirect and the misaligned-fetch flag.
    // The flag follows the alignment of every PC write, so an exception
    // (which always writes the aligned vector) clears it as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            boot_cnt    <= '0;
            pend_target <= '0;
            fetch_adel  <= 1'b0;
        end else begin
            state       <= next_state;
            boot_cnt    <= next_cnt;
            pend_target <= next_pend;
            if (pc_ce) begin
                fetch_adel <= |pc_d[1:0];
            end
        end
    end

    // Next-PC selection and state transitions. Exceptions and ERET write the
    // PC even when fetch is stalled, since they must redirect immediately;
    // a branch that cannot be taken yet is parked in PEND. A branch does not
    // flush IF because its delay-slot instruction is already being fetched.
    always_comb begin
        next_state = state;
        next_cnt   = boot_cnt;
        next_pend  = pend_target;
        pc_d       = pc_q;
        pc_ce      = 1'b0;
        if_flush   = 1'b0;

        if (rst) begin
            pc_d = RESET_VEC;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == CNT_LAST) begin
                        next_state = RUN;
                    end else begin
                        next_cnt = boot_cnt + 1'b1;
                    end
                end
                RUN, PEND: begin
                    if (exc_req) begin
                        pc_d       = EXC_VEC;
                        pc_ce      = 1'b1;
                        if_flush   = 1'b1;
                        next_pend  = '0;
                        next_state = RUN;
                    end else if (eret) begin
                        pc_d       = epc;
                        pc_ce      = 1'b1;
                        if_flush   = 1'b1;
                        next_pend  = '0;
                        next_state = RUN;
                    end else if (state == PEND && advance) begin
                        pc_d       = pend_target;
                        pc_ce      = 1'b1;
                        next_state = RUN;
                    end else if (br_valid && advance) begin
                        pc_d       = br_target;
                        pc_ce      = 1'b1;
                        next_state = RUN;
                    end else if (br_valid) begin
                        next_pend  = br_target;
                        next_state = PEND;
                    end else if (advance) begin
                        pc_d  = pc_q + 32'd4;
                        pc_ce = 1'b1;
                    end
                end
                default: begin
                    next_state = BOOT;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    assign busy_boot   = rst || (state == BOOT);
    assign fetch_valid = !rst && (state != BOOT) && imem_ready && !if_flush;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the IF stage of the 5-stage MIPS pipeline. It drives the D/CE inputs of the 32-bit PC register and reads back its Q.
- Chooses among sequential, branch/jump, exception-vector and ERET targets.
- Holds redirects that arrive while fetch is stalled, and sequences a short boot hold after reset.

Parameters:
- RESET_VEC, 32'hBFC00000: PC register reset value, used for reporting only.
- EXC_VEC, 32'hBFC00380: general exception vector.
- BOOT_CYCLES, 2: cycles PC is held at RESET_VEC after reset release (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_q  in  32  current PC from PC register
- pc_d  out  32  next PC to PC register
- pc_ce  out  1  PC register write enable
- stall  in  1  hazard-unit IF/ID stall
- imem_ready  in  1  instruction memory ack for current fetch
- br_valid  in  1  ID-stage branch/jump taken (1-cycle pulse)
- br_target  in  32  branch/jump target
- exc_req  in  1  exception taken (MEM stage, 1-cycle pulse)
- eret  in  1  ERET committed (1-cycle pulse)
- epc  in  32  EPC value from CP0
- if_flush  out  1  kill instruction in IF/ID
- fetch_valid  out  1  IF instruction valid this cycle
- fetch_adel  out  1  misaligned fetch address error (registered)
- busy_boot  out  1  in BOOT state

Behaviour:
- States: BOOT, RUN, PEND. Reset → BOOT, boot counter = 0, pend_target = 0, fetch_adel = 0.
- Outputs during rst: pc_ce=0, if_flush=0, fetch_valid=0, busy_boot=1.
- BOOT:
  - pc_ce=0, fetch_valid=0.
  - Counter increments each cycle; on reaching BOOT_CYCLES-1 → RUN.
  - exc_req, eret and br_valid are ignored in BOOT.
- advance = !stall && imem_ready (RUN/PEND only).
- Priority, highest first, evaluated combinationally each cycle in RUN/PEND:
  1. exc_req: pc_d=EXC_VEC, pc_ce=1 regardless of advance; if_flush=1; discard pending redirect; → RUN.
  2. eret: pc_d=epc, pc_ce=1 regardless of advance; if_flush=1; discard pending; → RUN.
  3. PEND and advance: pc_d=pend_target, pc_ce=1; → RUN.
  4. br_valid and advance: pc_d=br_target, pc_ce=1; stay RUN.
  5. br_valid and !advance: latch pend_target=br_target; pc_ce=0; → PEND.
  6. advance: pc_d=pc_q+4 (32-bit wrap, 0xFFFFFFFC+4=0), pc_ce=1.
  7. else: pc_ce=0, pc_d=pc_q.
- br_valid arriving while already in PEND overwrites pend_target, last one wins. Cannot occur legally but must not corrupt state.
- Branch redirect does not flush IF: the delay-slot instruction is already in fetch. if_flush asserts only for exc_req/eret, same cycle, combinational.
- fetch_valid = (state != BOOT) && imem_ready && !if_flush.
- fetch_adel:
  - Registered; set the cycle after pc_ce=1 with pc_d[1:0]≠0.
  - Cleared the cycle after any pc_ce=1 with aligned pc_d, and on exc_req.
  - The PC is still written with the misaligned value; the exception unit consumes the flag.
- Latency: a redirect accepted in cycle N makes pc_q = target in N+1.
- Reset mid-operation (any state, incl. PEND) returns to BOOT and drops pending.
- exc_req and eret in the same cycle: exc_req wins.

Test Plan:
- Reset 3 cycles, release, imem_ready=1, stall=0 → busy_boot=1 for 2 cycles, pc_ce=0; then pc_q sequence 0xBFC00000, 0xBFC00004, 0xBFC00008.
- RUN at 0xBFC00010, br_valid=1, br_target=0xBFC00100, advance=1 → next cycle pc_q=0xBFC00100, if_flush=0 throughout.
- stall=1, br_valid pulse target 0x80000040, hold stall 3 cycles → state PEND, pc_ce=0; stall drop → pc_q=0x80000040 next cycle, state RUN.
- In PEND (target 0x80000040), exc_req=1 with stall=1 → if_flush=1, pc_q=0xBFC00380 next cycle, pending discarded; later un-stall yields 0xBFC00384.
- exc_req and eret same cycle, epc=0x80001000 → pc_q=0xBFC00380; then eret alone → pc_q=0x80001000, if_flush=1 for one cycle.
- br_target=0x80000042 → pc_q=0x80000042, fetch_adel=1 next cycle; next aligned sequential write clears it. Also pc_q=0xFFFFFFFC advances to 0x00000000.
